// File: rtl/controle_vagas_pkg.sv
// Shared types and constants for the parking vacancy controller (package vagas_pkg).
// Holds the counter width, the gate FSM state encoding and the two's-complement deltas.
package vagas_pkg;

  localparam int LARGURA_VAGAS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ABERTA  = 2'd1,
    AGUARDA = 2'd2
  } estado_cancela_t;

  localparam logic [LARGURA_VAGAS-1:0] DELTA_MENOS = 4'b1111;
  localparam logic [LARGURA_VAGAS-1:0] DELTA_MAIS  = 4'b0001;
  localparam logic [LARGURA_VAGAS-1:0] DELTA_ZERO  = 4'b0000;

endpackage

// File: rtl/controle_vagas_cancela_fsm.sv
// One gate: request edge detect, IDLE/ABERTA/AGUARDA FSM and open-time down-counter.
// With CONTROLE_VAGAS_SINC_EN defined the request first passes a 2-flop synchronizer.
module cancela_fsm
  import vagas_pkg::*;
#(
  parameter int TEMPO_CANCELA = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic permite,
  output logic cancela,
  output logic aceita,
  output logic recusa
);

  localparam logic [LARGURA_VAGAS-1:0] CARGA_TIMER = LARGURA_VAGAS'(TEMPO_CANCELA - 1);

  logic req_s;

`ifdef CONTROLE_VAGAS_SINC_EN
  logic [1:0] sinc_q, sinc_d;

  always_comb begin
    sinc_d = {sinc_q[0], req};
  end

  always_ff @(posedge clk) begin
    if (rst) sinc_q <= 2'b00;
    else     sinc_q <= sinc_d;
  end

  assign req_s = sinc_q[1];
`else
  assign req_s = req;
`endif

  logic                     req_q, req_d;
  logic                     req_ant_q, req_ant_d;
  logic                     borda;
  estado_cancela_t          estado_q, estado_d;
  logic [LARGURA_VAGAS-1:0] timer_q, timer_d;

  // req_q is the sampled request, req_ant_q the sample one cycle older.
  assign borda = req_q & ~req_ant_q;

  always_comb begin
    req_d     = req_s;
    req_ant_d = req_q;
    estado_d  = estado_q;
    timer_d   = timer_q;
    aceita    = 1'b0;
    recusa    = 1'b0;
    unique case (estado_q)
      IDLE: begin
        if (borda) begin
          if (permite) begin
            estado_d = ABERTA;
            timer_d  = CARGA_TIMER;
            aceita   = 1'b1;
          end else begin
            estado_d = AGUARDA;
            recusa   = 1'b1;
          end
        end
      end
      ABERTA: begin
        if (timer_q == '0) estado_d = AGUARDA;
        else               timer_d  = timer_q - 1'b1;
      end
      AGUARDA: begin
        if (!req_q) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      req_ant_q <= 1'b0;
      estado_q  <= IDLE;
      timer_q   <= '0;
    end else begin
      req_q     <= req_d;
      req_ant_q <= req_ant_d;
      estado_q  <= estado_d;
      timer_q   <= timer_d;
    end
  end

  assign cancela = (estado_q == ABERTA);

endmodule

// File: rtl/controle_vagas.sv
// Parking vacancy controller: free-space register updated by entry/exit gate FSMs.
// Optional CONTROLE_VAGAS_SINC_EN adds input synchronizers inside each gate.
module controle_vagas
  import vagas_pkg::*;
#(
  parameter int CAPACIDADE    = 9,
  parameter int TEMPO_CANCELA = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     entrada_req,
  input  logic                     saida_req,
  output logic                     cancela_ent,
  output logic                     cancela_sai,
  output logic [LARGURA_VAGAS-1:0] vagas,
  output logic                     lotado,
  output logic                     vazio,
  output logic                     recusado,
  output logic                     erro_saida
);

  localparam logic [LARGURA_VAGAS-1:0] CAP_VAGAS = LARGURA_VAGAS'(CAPACIDADE);

  logic [LARGURA_VAGAS-1:0] vagas_q, vagas_d;
  logic [LARGURA_VAGAS-1:0] delta;
  logic                     recusado_q, recusado_d;
  logic                     erro_q, erro_d;
  logic                     ent_aceita, ent_recusa;
  logic                     sai_aceita, sai_recusa;

  // Both permissions look at the pre-update count, so a simultaneous pair resolves independently.
  cancela_fsm #(.TEMPO_CANCELA(TEMPO_CANCELA)) u_cancela_ent (
    .clk     (clk),
    .rst     (rst),
    .req     (entrada_req),
    .permite (vagas_q != '0),
    .cancela (cancela_ent),
    .aceita  (ent_aceita),
    .recusa  (ent_recusa)
  );

  cancela_fsm #(.TEMPO_CANCELA(TEMPO_CANCELA)) u_cancela_sai (
    .clk     (clk),
    .rst     (rst),
    .req     (saida_req),
    .permite (vagas_q != CAP_VAGAS),
    .cancela (cancela_sai),
    .aceita  (sai_aceita),
    .recusa  (sai_recusa)
  );

  always_comb begin
    delta = DELTA_ZERO;
    unique case ({ent_aceita, sai_aceita})
      2'b10:   delta = DELTA_MENOS;
      2'b01:   delta = DELTA_MAIS;
      default: delta = DELTA_ZERO;
    endcase
    vagas_d    = vagas_q + delta;
    recusado_d = ent_recusa;
    erro_d     = sai_recusa;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vagas_q    <= CAP_VAGAS;
      recusado_q <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      vagas_q    <= vagas_d;
      recusado_q <= recusado_d;
      erro_q     <= erro_d;
    end
  end

  assign vagas      = vagas_q;
  assign lotado     = (vagas_q == '0);
  assign vazio      = (vagas_q == CAP_VAGAS);
  assign recusado   = recusado_q;
  assign erro_saida = erro_q;

endmodule

// File: doc/controle_vagas.md
# controle_vagas

Sequential vacancy controller for the parking lot. It tracks free spaces with a 4-bit counter that moves in both directions. An entry request subtracts one space and an exit request adds one. Each request drives its own timed gate-open pulse. It sits between the gate sensor inputs and the display/gate actuator logic, and is the decrementing, stateful counterpart to the team's 4-bit adder datapath.

## Interface
- CAPACIDADE, 9: total spaces; legal range 1..15.
- TEMPO_CANCELA, 4: cycles a gate output stays high; legal range 1..15.
- clk  in  1  system clock; one clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- entrada_req  in  1  entry sensor; level-high while a car waits at entry.
- saida_req  in  1  exit sensor; level-high while a car waits at exit.
- cancela_ent  out  1  entry gate open.
- cancela_sai  out  1  exit gate open.
- vagas  out  4  free spaces, 0..CAPACIDADE.
- lotado  out  1  high when vagas == 0.
- vazio  out  1  high when vagas == CAPACIDADE.
- recusado  out  1  one-cycle pulse: entry refused because the lot is full.
- erro_saida  out  1  one-cycle pulse: exit request arrived while the lot was empty.

## Operation
- Each gate has an independent FSM with states IDLE, ABERTA and AGUARDA.
- IDLE: a rising edge on the request is accepted. The edge is registered previous-value vs current.
  - Entry with vagas > 0: go to ABERTA and decrement vagas.
  - Entry with vagas == 0: pulse recusado, go to AGUARDA, vagas unchanged.
  - Exit with vagas < CAPACIDADE: go to ABERTA and increment vagas.
  - Exit with vagas == CAPACIDADE: pulse erro_saida, go to AGUARDA, vagas unchanged.
- ABERTA: the gate output is high. A down-counter loads TEMPO_CANCELA-1. When the counter reaches 0, go to AGUARDA.
- AGUARDA: the gate output is low. Wait for the request to go low, then return to IDLE. Edges seen outside IDLE are ignored.
- Arithmetic: the update is vagas + delta in 4-bit two's complement.
  - Decrement adds 4'b1111.
  - Increment adds 4'b0001.
  - Simultaneous accepted entry and exit give delta 0, so vagas is unchanged while both gates open.
- Simultaneous entry and exit when vagas == 0:
  - The exit is evaluated against the pre-update value and is accepted.
  - The entry is evaluated against the pre-update value and is refused.
  - Net result: vagas becomes 1 and recusado pulses.
- The same rule applies to the mirror case, exit plus entry when vazio.
- vagas can never wrap: the guards make 0→15 and CAPACIDADE→CAPACIDADE+1 unreachable.
- lotado and vazio are combinational decodes of the registered vagas.

## Timing
- Reset values:
  - vagas = CAPACIDADE, vazio = 1, lotado = 0.
  - cancela_ent = cancela_sai = 0, recusado = erro_saida = 0.
  - Both FSMs in IDLE.
  - The edge-detect history registers are cleared to 0.
- Reset is a synchronous override. Reset asserted during ABERTA drops the gate on the next edge and restores vagas to CAPACIDADE.
- A request held high through reset release is seen as a rising edge on the first cycle out of reset.
- Latency: the request goes high, is sampled at edge N, and is detected at N. At edge N+1, vagas updates, the gate output rises, and recusado/erro_saida pulse.
- The gate is high for exactly TEMPO_CANCELA cycles.
- Minimum request period: TEMPO_CANCELA + 2 cycles, plus the request low time.

## Configuration
- CONTROLE_VAGAS_SINC_EN defined: entrada_req and saida_req each pass through a 2-flop synchronizer before edge detection. All input-to-output latencies grow by 2 cycles. Reset clears the synchronizer flops to 0.
- Undefined: the inputs are sampled directly and are required to be synchronous to clk.

## Structure
- Shared package vagas_pkg holds:
  - Counter width constant LARGURA_VAGAS = 4.
  - Enum estado_cancela_t {IDLE, ABERTA, AGUARDA}.
  - Delta constants DELTA_MENOS = 4'b1111 and DELTA_MAIS = 4'b0001.
- One sub-module, cancela_fsm, instantiated twice (entry, exit). It contains the edge detect, FSM and timer.
  - Inputs: the request and an accept-permission signal.
  - Outputs: the gate level, an accept pulse and a refuse pulse.
- The top level holds the vacancy register, the delta mux, and the full/empty decodes.

## Test plan
- Reset then idle: vagas = 9, vazio = 1, lotado = 0, gates low, for 10 cycles.
- One entry pulse:
  - vagas goes 9→8 one cycle after the sample edge.
  - cancela_ent is high for exactly 4 cycles.
  - A second edge while ABERTA is ignored.
- Nine entries, then a tenth:
  - vagas reaches 0 and lotado = 1.
  - The tenth entry pulses recusado once, cancela_ent stays low, and vagas stays 0.
- Exit at reset (vagas = 9): erro_saida pulses once, vagas stays 9, cancela_sai stays low.
- Simultaneous entry and exit:
  - At vagas = 5: both gates open and vagas stays 5.
  - At vagas = 0: vagas becomes 1, cancela_sai opens, recusado pulses, cancela_ent stays low.
- rst asserted mid-ABERTA at vagas = 3: the next edge gives vagas = 9 and gates low. A held request re-triggers on the first cycle after release. Repeat with CONTROLE_VAGAS_SINC_EN and check the +2-cycle latency.
